// File: rtl/stopwatch_counter_p.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter_p
// Purpose  : Parametrised BCD MM:SS stopwatch core. Counts up or down on a
//            1 Hz enable. A pause edge toggles run/pause. In adjust mode a
//            selected digit can be auto-incremented or loaded directly.
//            An optional lap hold freezes the displayed value.
// Params   : MIN_LIMIT     - top minutes value (1..99); top count MIN_LIMIT:59
//            START_RUNNING - value of running after reset
// Ports    : clk_c        in   system clock, rising edge
//            reset_c      in   synchronous active-low reset
//            tick_c       in   one-cycle count enable
//            adj_tick_c   in   one-cycle adjust enable
//            pause_c      in   pause level; a rising edge toggles running
//            dir_c        in   0 = up, 1 = down
//            ADJ          in   adjust mode; counting is suppressed
//            SEL[1:0]     in   adjust digit (sec_ones, sec_tens, min_ones,
//                              min_tens)
//            load_c       in   load NUM into the selected digit
//            NUM[3:0]     in   load value
//            lap_c        in   lap level; a rising edge toggles lap hold
//            min_tens, min_ones, sec_tens, sec_ones [3:0] out  BCD digits
//            running      out  count enabled
//            expire       out  one-cycle wrap / terminal-zero pulse
//            lap_active   out  display frozen on the lap value
// Build    : define STOPWATCH_LAP_EN to include the lap-hold logic
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter_p #(
  parameter int MIN_LIMIT     = 59,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       tick_c,
  input  logic       adj_tick_c,
  input  logic       pause_c,
  input  logic       dir_c,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  input  logic       load_c,
  input  logic [3:0] NUM,
  input  logic       lap_c,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expire,
  output logic       lap_active
);

  localparam logic [3:0] c_MT_MAX = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] c_MO_MAX = 4'(MIN_LIMIT % 10);

  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic       r_running, r_expire;
  logic       r_pause_s, r_pause_q;

  logic [3:0] w_mt, w_mo, w_st, w_so;
  logic [3:0] w_dmax, w_cur, w_new;
  logic       w_expire, w_stop, w_pause_rise;
  logic       w_at_top, w_at_zero, w_at_one;

  // Edge is taken from two registered samples, so running flips one cycle
  // after the edge is first seen.
  assign w_pause_rise = r_pause_s & ~r_pause_q;

  assign w_at_top  = (r_mt == c_MT_MAX) && (r_mo == c_MO_MAX) &&
                     (r_st == 4'd5) && (r_so == 4'd9);
  assign w_at_zero = (r_mt == 4'd0) && (r_mo == 4'd0) &&
                     (r_st == 4'd0) && (r_so == 4'd0);
  assign w_at_one  = (r_mt == 4'd0) && (r_mo == 4'd0) &&
                     (r_st == 4'd0) && (r_so == 4'd1);

  // Selected digit, its legal maximum and its adjusted value
  always_comb begin
    w_dmax = 4'd9;
    w_cur  = r_so;
    case (SEL)
      2'b00:   begin w_dmax = 4'd9;     w_cur = r_so; end
      2'b01:   begin w_dmax = 4'd5;     w_cur = r_st; end
      2'b10:   begin w_dmax = 4'd9;     w_cur = r_mo; end
      default: begin w_dmax = c_MT_MAX; w_cur = r_mt; end
    endcase
    if (load_c) begin
      w_new = (NUM > w_dmax) ? w_dmax : NUM;
    end else begin
      w_new = (w_cur >= w_dmax) ? 4'd0 : w_cur + 4'd1;
    end
  end

  always_comb begin
    w_mt     = r_mt;
    w_mo     = r_mo;
    w_st     = r_st;
    w_so     = r_so;
    w_expire = 1'b0;
    w_stop   = 1'b0;
    if (ADJ) begin
      if (load_c || adj_tick_c) begin
        case (SEL)
          2'b00:   w_so = w_new;
          2'b01:   w_st = w_new;
          2'b10:   w_mo = w_new;
          default: w_mt = w_new;
        endcase
        // Keep minutes at or below MIN_LIMIT after any edit
        if ((w_mt == c_MT_MAX) && (w_mo > c_MO_MAX)) begin
          w_mo = c_MO_MAX;
        end
      end
    end else if (r_running && tick_c) begin
      if (!dir_c) begin
        if (w_at_top) begin
          w_mt     = 4'd0;
          w_mo     = 4'd0;
          w_st     = 4'd0;
          w_so     = 4'd0;
          w_expire = 1'b1;
        end else if (r_so != 4'd9) begin
          w_so = r_so + 4'd1;
        end else begin
          w_so = 4'd0;
          if (r_st != 4'd5) begin
            w_st = r_st + 4'd1;
          end else begin
            w_st = 4'd0;
            if (r_mo != 4'd9) begin
              w_mo = r_mo + 4'd1;
            end else begin
              w_mo = 4'd0;
              w_mt = r_mt + 4'd1;
            end
          end
        end
      end else begin
        // Terminal zero: a tick at 00:01 or at 00:00 ends the run
        if (w_at_zero || w_at_one) begin
          w_expire = 1'b1;
          w_stop   = 1'b1;
        end
        if (!w_at_zero) begin
          if (r_so != 4'd0) begin
            w_so = r_so - 4'd1;
          end else begin
            w_so = 4'd9;
            if (r_st != 4'd0) begin
              w_st = r_st - 4'd1;
            end else begin
              w_st = 4'd5;
              if (r_mo != 4'd0) begin
                w_mo = r_mo - 4'd1;
              end else begin
                w_mo = 4'd9;
                w_mt = r_mt - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_c) begin
    if (!reset_c) begin
      r_mt      <= 4'd0;
      r_mo      <= 4'd0;
      r_st      <= 4'd0;
      r_so      <= 4'd0;
      r_running <= START_RUNNING;
      r_expire  <= 1'b0;
      // Both samples track the level so a pause held through reset is
      // not seen as an edge afterwards.
      r_pause_s <= pause_c;
      r_pause_q <= pause_c;
    end else begin
      r_mt      <= w_mt;
      r_mo      <= w_mo;
      r_st      <= w_st;
      r_so      <= w_so;
      r_expire  <= w_expire;
      r_running <= w_stop ? 1'b0 : (r_running ^ w_pause_rise);
      r_pause_s <= pause_c;
      r_pause_q <= r_pause_s;
    end
  end

  assign running = r_running;
  assign expire  = r_expire;

`ifdef STOPWATCH_LAP_EN
  logic       r_lap_s, r_lap_q, r_lap_active;
  logic [3:0] r_lap_mt, r_lap_mo, r_lap_st, r_lap_so;
  logic       w_lap_rise;

  assign w_lap_rise = r_lap_s & ~r_lap_q;

  always_ff @(posedge clk_c) begin
    if (!reset_c) begin
      r_lap_s      <= lap_c;
      r_lap_q      <= lap_c;
      r_lap_active <= 1'b0;
      r_lap_mt     <= 4'd0;
      r_lap_mo     <= 4'd0;
      r_lap_st     <= 4'd0;
      r_lap_so     <= 4'd0;
    end else begin
      r_lap_s <= lap_c;
      r_lap_q <= r_lap_s;
      if (ADJ) begin
        r_lap_active <= 1'b0;
      end else if (w_lap_rise) begin
        if (!r_lap_active) begin
          r_lap_mt     <= r_mt;
          r_lap_mo     <= r_mo;
          r_lap_st     <= r_st;
          r_lap_so     <= r_so;
          r_lap_active <= 1'b1;
        end else begin
          r_lap_active <= 1'b0;
        end
      end
    end
  end

  assign min_tens   = r_lap_active ? r_lap_mt : r_mt;
  assign min_ones   = r_lap_active ? r_lap_mo : r_mo;
  assign sec_tens   = r_lap_active ? r_lap_st : r_st;
  assign sec_ones   = r_lap_active ? r_lap_so : r_so;
  assign lap_active = r_lap_active;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap_c;

  assign min_tens   = r_mt;
  assign min_ones   = r_mo;
  assign sec_tens   = r_st;
  assign sec_ones   = r_so;
  assign lap_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_counter_p
// Purpose  : Scoreboard bench for stopwatch_counter_p. Two instances run on
//            shared stimulus (MIN_LIMIT 59 and 9). A time-in-seconds
//            reference model produces the expected outputs, which are queued.
//            A monitor pops the queue and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter_p;

  logic clk_c = 1'b0;
  always #5 clk_c = ~clk_c;

  logic       reset_c = 1'b0, tick_c = 1'b0, adj_tick_c = 1'b0, pause_c = 1'b0;
  logic       dir_c = 1'b0, ADJ = 1'b0, load_c = 1'b0, lap_c = 1'b0;
  logic [1:0] SEL = 2'd0;
  logic [3:0] NUM = 4'd0;

  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_run, a_exp, a_lap, b_run, b_exp, b_lap;

  stopwatch_counter_p #(.MIN_LIMIT(59), .START_RUNNING(1'b0)) u_dut59 (
    .clk_c(clk_c), .reset_c(reset_c), .tick_c(tick_c), .adj_tick_c(adj_tick_c),
    .pause_c(pause_c), .dir_c(dir_c), .ADJ(ADJ), .SEL(SEL), .load_c(load_c),
    .NUM(NUM), .lap_c(lap_c), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .running(a_run), .expire(a_exp),
    .lap_active(a_lap)
  );

  stopwatch_counter_p #(.MIN_LIMIT(9), .START_RUNNING(1'b0)) u_dut9 (
    .clk_c(clk_c), .reset_c(reset_c), .tick_c(tick_c), .adj_tick_c(adj_tick_c),
    .pause_c(pause_c), .dir_c(dir_c), .ADJ(ADJ), .SEL(SEL), .load_c(load_c),
    .NUM(NUM), .lap_c(lap_c), .min_tens(b_mt), .min_ones(b_mo),
    .sec_tens(b_st), .sec_ones(b_so), .running(b_run), .expire(b_exp),
    .lap_active(b_lap)
  );

  // Reference state: count kept as total seconds
  typedef struct {
    int secs;
    bit run;
    bit exp;
    bit lact;
    int lsecs;
    bit ps, pq, ls, lq;
  } mdl_t;

  typedef struct packed {
    logic [18:0] e59;
    logic [18:0] e9;
  } exp_t;

  mdl_t m59, m9;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void step(inout mdl_t m, input int lim);
    int mt, mo, st, so, mx, cur, nv, top, old;
    bit rp, rl, stop;
    if (!reset_c) begin
      m.secs = 0; m.run = 1'b0; m.exp = 1'b0; m.lact = 1'b0;
      m.ps = pause_c; m.pq = pause_c; m.ls = lap_c; m.lq = lap_c;
      return;
    end
    old  = m.secs;
    rp   = m.ps && !m.pq;
    rl   = m.ls && !m.lq;
    m.exp = 1'b0;
    stop = 1'b0;
    top  = lim * 60 + 59;
    if (ADJ) begin
      if (load_c || adj_tick_c) begin
        mt = m.secs / 600; mo = (m.secs / 60) % 10;
        st = (m.secs % 60) / 10; so = m.secs % 10;
        case (SEL)
          2'd0:    begin mx = 9;        cur = so; end
          2'd1:    begin mx = 5;        cur = st; end
          2'd2:    begin mx = 9;        cur = mo; end
          default: begin mx = lim / 10; cur = mt; end
        endcase
        if (load_c) nv = (int'(NUM) > mx) ? mx : int'(NUM);
        else        nv = (cur == mx) ? 0 : cur + 1;
        case (SEL)
          2'd0:    so = nv;
          2'd1:    st = nv;
          2'd2:    mo = nv;
          default: mt = nv;
        endcase
        if (mt * 10 + mo > lim) mo = lim % 10;
        m.secs = (mt * 10 + mo) * 60 + st * 10 + so;
      end
    end else if (m.run && tick_c) begin
      if (!dir_c) begin
        if (m.secs == top) begin m.secs = 0; m.exp = 1'b1; end
        else m.secs = m.secs + 1;
      end else begin
        if (m.secs > 0) m.secs = m.secs - 1;
        if (m.secs == 0) begin m.exp = 1'b1; stop = 1'b1; end
      end
    end
    m.run = stop ? 1'b0 : (m.run ^ rp);
`ifdef STOPWATCH_LAP_EN
    if (ADJ) m.lact = 1'b0;
    else if (rl) begin
      if (!m.lact) begin m.lsecs = old; m.lact = 1'b1; end
      else m.lact = 1'b0;
    end
`else
    m.lact = 1'b0;
    m.lsecs = rl ? old : m.lsecs;
`endif
    m.pq = m.ps; m.ps = pause_c;
    m.lq = m.ls; m.ls = lap_c;
  endfunction

  function automatic logic [18:0] pk(input mdl_t m);
    int d;
    d = m.lact ? m.lsecs : m.secs;
    return {4'(d / 600), 4'((d / 60) % 10), 4'((d % 60) / 10), 4'(d % 10),
            m.run, m.exp, m.lact};
  endfunction

  // One clock: model consumes the inputs sampled at this edge
  task automatic cycle();
    exp_t e;
    @(posedge clk_c);
    step(m59, 59);
    step(m9, 9);
    e.e59 = pk(m59);
    e.e9  = pk(m9);
    q.push_back(e);
    @(negedge clk_c);
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_c = 1'b1; cycle();
      tick_c = 1'b0; cycle();
    end
  endtask

  task automatic ld(input logic [1:0] s, input logic [3:0] v);
    ADJ = 1'b1; SEL = s; NUM = v; load_c = 1'b1; cycle();
    load_c = 1'b0; cycle();
  endtask

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t got mm:ss/run/exp/lap=%h expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: registered outputs are presented every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_c);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dut59", {a_mt, a_mo, a_st, a_so, a_run, a_exp, a_lap}, e.e59);
        check("dut9",  {b_mt, b_mo, b_st, b_so, b_run, b_exp, b_lap}, e.e9);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m59 = '{default: 0};
    m9  = '{default: 0};
    // Reset, pause edge, 60 ticks up
    reset_c = 1'b0; cycle(); cycle();
    reset_c = 1'b1; cycle();
    pause_c = 1'b1; cycle(); cycle(); cycle();
    pulse_tick(60);
    // Preload 59:58 (09:58 on the MIN_LIMIT=9 instance), then wrap
    ld(2'd3, 4'd5); ld(2'd2, 4'd9); ld(2'd1, 4'd5); ld(2'd0, 4'd8);
    ADJ = 1'b0; cycle();
    pulse_tick(1); pulse_tick(1); pulse_tick(1);
    // Preload 00:02, count down to terminal zero and one extra tick
    ld(2'd3, 4'd0); ld(2'd2, 4'd0); ld(2'd1, 4'd0); ld(2'd0, 4'd2);
    ADJ = 1'b0; dir_c = 1'b1; cycle();
    pulse_tick(3);
    // Clamped load and min_tens auto-increment, ticks present throughout
    ADJ = 1'b1; tick_c = 1'b1; SEL = 2'd1; NUM = 4'd8; load_c = 1'b1; cycle();
    load_c = 1'b0; SEL = 2'd3;
    for (int i = 0; i < 6; i++) begin
      adj_tick_c = 1'b1; cycle();
      adj_tick_c = 1'b0; cycle();
    end
    tick_c = 1'b0; ADJ = 1'b0; dir_c = 1'b0; cycle();
    // Coincident tick and pause edge at 00:10 while running
    pause_c = 1'b0; reset_c = 1'b0; cycle(); reset_c = 1'b1; cycle();
    pause_c = 1'b1; cycle(); cycle(); pause_c = 1'b0;
    pulse_tick(10);
    pause_c = 1'b1; cycle(); tick_c = 1'b1; cycle(); tick_c = 1'b0; cycle(); cycle();
    // Reset mid-count with pause held high
    pause_c = 1'b0; cycle(); pause_c = 1'b1; cycle(); cycle();
    pulse_tick(3);
    reset_c = 1'b0; cycle(); reset_c = 1'b1; cycle(); cycle(); cycle();
    // Lap capture and release
    pause_c = 1'b0; cycle(); pause_c = 1'b1; cycle(); cycle();
    pulse_tick(5);
    lap_c = 1'b1; cycle(); cycle();
    pulse_tick(10);
    lap_c = 1'b0; cycle(); lap_c = 1'b1; cycle(); cycle(); cycle();
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset_c    = ($urandom_range(0, 299) != 0);
      tick_c     = ($urandom_range(0, 2) == 0);
      adj_tick_c = ($urandom_range(0, 3) == 0);
      load_c     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 14) == 0) pause_c = ~pause_c;
      if ($urandom_range(0, 19) == 0) lap_c = ~lap_c;
      if ($urandom_range(0, 39) == 0) dir_c = ~dir_c;
      if ($urandom_range(0, 29) == 0) ADJ = ~ADJ;
      SEL = 2'($urandom_range(0, 3));
      NUM = 4'($urandom_range(0, 15));
      cycle();
    end
    @(posedge clk_c);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
